// File: rtl/find_min_5_vals_cascading_if.sv
// Sample-set bus for the five-input minimum finder.
// Master drives the candidates, slave returns the selected minimum.
interface find_min_5_vals_cascading_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic [WIDTH-1:0] input1;
   logic [WIDTH-1:0] input2;
   logic [WIDTH-1:0] input3;
   logic [WIDTH-1:0] input4;
   logic [WIDTH-1:0] input5;
   logic [2:0]       output_index;
   logic [WIDTH-1:0] min_value;
   logic             out_valid;

   modport master (
      output in_valid,
      output input1,
      output input2,
      output input3,
      output input4,
      output input5,
      input  output_index,
      input  min_value,
      input  out_valid
   );

   modport slave (
      input  in_valid,
      input  input1,
      input  input2,
      input  input3,
      input  input4,
      input  input5,
      output output_index,
      output min_value,
      output out_valid
   );
endinterface

// File: rtl/find_min_5_vals_cascading.sv
// Three-stage pipelined minimum of five unsigned samples.
// Returns the 1-based index of the minimum; lower index wins ties.
module find_min_5_vals_cascading #(
   parameter int WIDTH = 8
) (
   input logic clock,
   input logic reset,
   find_min_5_vals_cascading_if.slave bus
);
   logic [WIDTH-1:0] a_val, b_val, e1_val;
   logic [2:0]       a_idx, b_idx;
   logic             v1;

   logic [WIDTH-1:0] c_val, e2_val;
   logic [2:0]       c_idx;
   logic             v2;

   logic [WIDTH-1:0] min_q;
   logic [2:0]       idx_q;
   logic             vld_q;

   // Strict less-than everywhere so the earlier operand keeps ties
   always_ff @(posedge clock) begin
      if (reset) begin
         a_val  <= '0;
         a_idx  <= '0;
         b_val  <= '0;
         b_idx  <= '0;
         e1_val <= '0;
         v1     <= 1'b0;
      end else begin
         if (bus.input2 < bus.input1) begin
            a_val <= bus.input2;
            a_idx <= 3'd2;
         end else begin
            a_val <= bus.input1;
            a_idx <= 3'd1;
         end
         if (bus.input4 < bus.input3) begin
            b_val <= bus.input4;
            b_idx <= 3'd4;
         end else begin
            b_val <= bus.input3;
            b_idx <= 3'd3;
         end
         e1_val <= bus.input5;
         v1     <= bus.in_valid;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         c_val  <= '0;
         c_idx  <= '0;
         e2_val <= '0;
         v2     <= 1'b0;
      end else begin
         if (b_val < a_val) begin
            c_val <= b_val;
            c_idx <= b_idx;
         end else begin
            c_val <= a_val;
            c_idx <= a_idx;
         end
         e2_val <= e1_val;
         v2     <= v1;
      end
   end

   // Outputs hold between valid results; bubbles never touch them
   always_ff @(posedge clock) begin
      if (reset) begin
         min_q <= '0;
         idx_q <= '0;
         vld_q <= 1'b0;
      end else begin
         vld_q <= v2;
         if (v2) begin
            if (e2_val < c_val) begin
               min_q <= e2_val;
               idx_q <= 3'd5;
            end else begin
               min_q <= c_val;
               idx_q <= c_idx;
            end
         end
      end
   end

   assign bus.output_index = idx_q;
   assign bus.min_value    = min_q;
   assign bus.out_valid    = vld_q;
endmodule

// File: tb/tb_find_min_5_vals_cascading.sv
// Directed-vector bench for the five-input minimum finder.
// Hand-computed expectations checked with immediate assertions.
module tb_find_min_5_vals_cascading;
   logic clock;
   logic reset;
   int   passed;
   int   total;

   find_min_5_vals_cascading_if #(.WIDTH(8)) bus ();

   find_min_5_vals_cascading #(.WIDTH(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic drive(input logic v, input int i1, input int i2,
                        input int i3, input int i4, input int i5);
      bus.in_valid = v;
      bus.input1   = i1[7:0];
      bus.input2   = i2[7:0];
      bus.input3   = i3[7:0];
      bus.input4   = i4[7:0];
      bus.input5   = i5[7:0];
   endtask

   task automatic run_set(input string tag, input int i1, input int i2,
                          input int i3, input int i4, input int i5,
                          input int eidx, input int emin);
      drive(1'b1, i1, i2, i3, i4, i5);
      tick();
      drive(1'b0, 0, 0, 0, 0, 0);
      tick();
      chk({tag, "_early"}, int'(bus.out_valid), 0);
      tick();
      chk({tag, "_valid"}, int'(bus.out_valid), 1);
      chk({tag, "_idx"}, int'(bus.output_index), eidx);
      chk({tag, "_min"}, int'(bus.min_value), emin);
      tick();
      chk({tag, "_pulse"}, int'(bus.out_valid), 0);
   endtask

   int sv [5][5];
   int sidx [5];
   int smin [5];

   initial begin
      passed = 0;
      total  = 0;
      sv   = '{'{1, 2, 3, 4, 5}, '{5, 4, 3, 2, 1}, '{7, 5, 3, 6, 7},
               '{9, 8, 7, 2, 3}, '{22, 2, 5, 11, 19}};
      sidx = '{1, 5, 3, 4, 2};
      smin = '{1, 1, 3, 2, 2};

      reset = 1'b1;
      drive(1'b0, 0, 0, 0, 0, 0);
      tick();
      tick();
      chk("rst_idx", int'(bus.output_index), 0);
      chk("rst_min", int'(bus.min_value), 0);
      chk("rst_valid", int'(bus.out_valid), 0);
      reset = 1'b0;

      run_set("asc",  1, 2, 3, 4, 5, 1, 1);
      run_set("desc", 5, 4, 3, 2, 1, 5, 1);
      run_set("mid",  7, 5, 3, 6, 7, 3, 3);
      run_set("b4",   9, 8, 7, 2, 3, 4, 2);
      run_set("b2",   22, 2, 5, 11, 19, 2, 2);

      for (int k = 0; k < 7; k++) begin
         if (k < 5)
            drive(1'b1, sv[k][0], sv[k][1], sv[k][2], sv[k][3], sv[k][4]);
         else
            drive(1'b0, 0, 0, 0, 0, 0);
         tick();
         if (k >= 2) begin
            chk($sformatf("stream%0d_valid", k - 2), int'(bus.out_valid), 1);
            chk($sformatf("stream%0d_idx", k - 2), int'(bus.output_index),
                sidx[k-2]);
            chk($sformatf("stream%0d_min", k - 2), int'(bus.min_value),
                smin[k-2]);
         end
      end
      tick();
      chk("stream_end", int'(bus.out_valid), 0);

      run_set("tie_all4", 4, 4, 4, 4, 4, 1, 4);
      run_set("tie_max0", 255, 255, 255, 255, 0, 5, 0);
      run_set("tie_all255", 255, 255, 255, 255, 255, 1, 255);
      run_set("tie_93", 9, 3, 9, 3, 3, 2, 3);

      drive(1'b0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("bubble%0d_valid", k), int'(bus.out_valid), 0);
      end
      chk("bubble_idx", int'(bus.output_index), 2);
      chk("bubble_min", int'(bus.min_value), 3);

      drive(1'b1, 1, 2, 3, 4, 5);
      tick();
      drive(1'b1, 5, 4, 3, 2, 1);
      tick();
      reset = 1'b1;
      drive(1'b1, 7, 5, 3, 6, 7);
      tick();
      chk("midrst_valid", int'(bus.out_valid), 0);
      chk("midrst_idx", int'(bus.output_index), 0);
      chk("midrst_min", int'(bus.min_value), 0);
      reset = 1'b0;
      drive(1'b0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("postrst%0d_valid", k), int'(bus.out_valid), 0);
      end
      chk("postrst_idx", int'(bus.output_index), 0);
      chk("postrst_min", int'(bus.min_value), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
